// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-master arbiter in front of the single-port synchronous data RAM.
//   master 0 : core load/store port
//   master 1 : debug / program-loader port
//
// Arbitration is round-robin on ties. A master may lock the RAM across several
// accesses. A watchdog forces the lock off after LOCK_MAX cycles. The RAM has a
// fixed 1-cycle read latency, so read data is routed back to whichever master
// issued the read on the previous cycle.
//
// Ports
//   clk, _rst              : rising-edge clock, asynchronous active-low reset
//   mX_req/we/addr/wdata/
//   mX_wstrb/mX_lock       : master X access request (held until granted)
//   mX_gnt                 : combinational accept for this cycle
//   mX_rvalid/mX_rdata     : read return, one cycle after a granted read
//   ram_en/we/addr/wdata   : RAM command (zero when nothing is granted)
//   ram_rdata              : RAM read data, valid 1 cycle after a read
//   lock_err               : one-cycle pulse when the watchdog drops a lock
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int LOCK_MAX = 16   // legal range 1..255
) (
  input  logic          clk,
  input  logic          _rst,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,

  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,

  output logic          lock_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  // Watchdog fires when the counter has reached this value in a lock state.
  localparam logic [7:0] CNT_LIMIT = 8'(LOCK_MAX - 1);

  state_e      state_q,    state_d;
  logic        last_gnt_q, last_gnt_d;   // master granted most recently
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        rd_pend_q,  rd_pend_d;
  logic        rd_owner_q, rd_owner_d;

  logic        gnt0, gnt1, any_gnt;
  logic        gnt_we, gnt_lock;
  logic        lock_err_c;

  // ---------------------------------------------------------------------------
  // Arbitration: purely a function of registered state and current requests.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          // Tie: the master that did not win last time goes now.
          gnt0 = last_gnt_q;
          gnt1 = ~last_gnt_q;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
      LOCK0:   gnt0 = m0_req;
      LOCK1:   gnt1 = m1_req;
      default: ;
    endcase
    // NOTE: the grants are combinational from the requests, so the async reset
    // must also mask them here; clearing the flops alone would not silence them.
    if (!_rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign gnt_we   = gnt1 ? m1_we   : m0_we;
  assign gnt_lock = gnt1 ? m1_lock : m0_lock;
  assign m0_gnt   = gnt0;
  assign m1_gnt   = gnt1;

  // ---------------------------------------------------------------------------
  // RAM command mux; everything idles at zero without a grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_en    = 1'b1;
      ram_we    = m0_we ? m0_wstrb : 4'b0000;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (gnt1) begin
      ram_en    = 1'b1;
      ram_we    = m1_we ? m1_wstrb : 4'b0000;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM, watchdog and round-robin history.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_gnt_d = any_gnt ? gnt1 : last_gnt_q;
    lock_err_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        lock_cnt_d = 8'd0;
        if (any_gnt && gnt_lock) state_d = gnt1 ? LOCK1 : LOCK0;
      end
      LOCK0, LOCK1: begin
        if (lock_cnt_q != 8'hFF) lock_cnt_d = lock_cnt_q + 8'd1;
        // In a lock state only the owner can hold a grant, so any grant here
        // is the owner's. An unlocking access wins over a coinciding expiry.
        if (any_gnt && !gnt_lock) begin
          state_d    = IDLE;
          lock_cnt_d = 8'd0;
        end else if (lock_cnt_q >= CNT_LIMIT) begin
          state_d    = IDLE;
          lock_cnt_d = 8'd0;
          lock_err_c = 1'b1;
          last_gnt_d = (state_q == LOCK1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lock_err = lock_err_c;

  // ---------------------------------------------------------------------------
  // Read return: remember who issued the read so the data goes back to them.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_pend_d  = any_gnt && !gnt_we;
    rd_owner_d = (any_gnt && !gnt_we) ? gnt1 : rd_owner_q;
  end

  assign m0_rvalid = rd_pend_q && !rd_owner_q;
  assign m1_rvalid = rd_pend_q &&  rd_owner_q;
  assign m0_rdata  = m0_rvalid ? ram_rdata : 32'd0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : 32'd0;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge _rst) begin
    // NOTE: flops are written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;   // master 0 wins the first tie
      lock_cnt_q <= 8'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with LOCK_MAX=4. A behavioural 64-word RAM
// with 1-cycle read latency sits behind the arbiter. Inputs change 1 ns after
// the rising edge; outputs are checked 5 ns after the edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;

  logic          m0_req, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic [3:0]    m0_wstrb;
  logic          m0_gnt, m0_rvalid;
  logic [31:0]   m0_rdata;

  logic          m1_req, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic [3:0]    m1_wstrb;
  logic          m1_gnt, m1_rvalid;
  logic [31:0]   m1_rdata;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          lock_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .LOCK_MAX(4)) dut (
    .clk       (clk),
    ._rst      (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_lock   (m0_lock),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .lock_err  (lock_err)
  );

  // Behavioural RAM: contents reload on reset, byte-enabled writes.
  logic [31:0] mem [0:63];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hAAAA_AAAA;
      mem[4]    <= 32'hDEAD_BEEF;   // 0x10
      mem[12]   <= 32'h1111_1111;   // 0x30
      mem[13]   <= 32'h2222_2222;   // 0x34
      ram_rdata <= 32'd0;
    end else if (ram_en) begin
      if (ram_we == 4'b0000) begin
        ram_rdata <= mem[ram_addr[7:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0; m0_lock = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0; m1_lock = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset: all outputs low even with requests present -----
    rst_n = 1'b0;
    clear_inputs();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h44; m0_wdata = 32'h5555_5555; m0_wstrb = 4'hF;
    m1_req = 1'b1; m1_addr = 32'h48;
    #3;
    check("rst_m0_gnt",    m0_gnt,    1'b0);
    check("rst_m1_gnt",    m1_gnt,    1'b0);
    check("rst_ram_en",    ram_en,    1'b0);
    check("rst_ram_we",    ram_we,    4'h0);
    check("rst_ram_addr",  ram_addr,  32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_rvalid",    {m0_rvalid, m1_rvalid}, 2'b00);
    check("rst_lock_err",  lock_err,  1'b0);
    clear_inputs();
    tick();
    rst_n = 1'b1;

    // ---------------- single m0 read of 0x10 --------------------------------
    m0_req = 1'b1; m0_addr = 32'h10;
    settle();
    check("rd_m0_gnt",   m0_gnt,   1'b1);
    check("rd_m1_gnt",   m1_gnt,   1'b0);
    check("rd_ram_en",   ram_en,   1'b1);
    check("rd_ram_we",   ram_we,   4'h0);
    check("rd_ram_addr", ram_addr, 32'h10);
    tick();
    clear_inputs();
    settle();
    check("rd_m0_rvalid", m0_rvalid, 1'b1);
    check("rd_m0_rdata",  m0_rdata,  32'hDEAD_BEEF);
    check("rd_m1_rvalid", m1_rvalid, 1'b0);
    check("rd_m1_rdata",  m1_rdata,  32'h0);
    check("rd_ram_en_idle", ram_en,  1'b0);

    // ---------------- round robin: both read for 4 cycles -------------------
    pulse_reset();
    m0_req = 1'b1; m0_addr = 32'h30;
    m1_req = 1'b1; m1_addr = 32'h34;
    for (int k = 0; k <= 4; k++) begin
      if (k == 4) clear_inputs();
      settle();
      if (k < 4) begin
        // grants alternate m0, m1, m0, m1
        check($sformatf("rr%0d_m0_gnt", k), m0_gnt, (k % 2 == 0));
        check($sformatf("rr%0d_m1_gnt", k), m1_gnt, (k % 2 == 1));
        check($sformatf("rr%0d_addr", k), ram_addr, (k % 2 == 0) ? 32'h30 : 32'h34);
      end
      if (k > 0) begin
        // read issued in cycle k-1 returns now to that master
        check($sformatf("rr%0d_m0_rvalid", k), m0_rvalid, (k % 2 == 1));
        check($sformatf("rr%0d_m1_rvalid", k), m1_rvalid, (k % 2 == 0));
        check($sformatf("rr%0d_m0_rdata", k), m0_rdata, (k % 2 == 1) ? 32'h1111_1111 : 32'h0);
        check($sformatf("rr%0d_m1_rdata", k), m1_rdata, (k % 2 == 0) ? 32'h2222_2222 : 32'h0);
      end
      tick();
    end

    // ---------------- m1 partial write, then read back ---------------------
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
    settle();
    check("wr_m1_gnt",    m1_gnt,    1'b1);
    check("wr_m0_gnt",    m0_gnt,    1'b0);
    check("wr_ram_we",    ram_we,    4'b0011);
    check("wr_ram_addr",  ram_addr,  32'h20);
    check("wr_ram_wdata", ram_wdata, 32'h1234_5678);
    tick();
    clear_inputs();
    settle();
    check("wr_no_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    tick();
    m1_req = 1'b1; m1_addr = 32'h20;
    settle();
    check("rb_m1_gnt", m1_gnt, 1'b1);
    tick();
    clear_inputs();
    settle();
    check("rb_m1_rvalid", m1_rvalid, 1'b1);
    check("rb_m1_rdata",  m1_rdata,  32'hAAAA_5678);
    check("rb_m0_rvalid", m0_rvalid, 1'b0);
    tick();

    // ---------------- m1 lock, m0 blocked until release ---------------------
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h34;
    settle();
    check("lk_c0_m1_gnt", m1_gnt, 1'b1);
    tick();
    clear_inputs();
    m0_req = 1'b1; m0_addr = 32'h10;
    settle();
    check("lk_c1_m0_gnt",    m0_gnt,    1'b0);
    check("lk_c1_m1_rvalid", m1_rvalid, 1'b1);
    check("lk_c1_m1_rdata",  m1_rdata,  32'h2222_2222);
    tick();
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = 32'h24; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF;
    settle();
    check("lk_c2_m1_gnt", m1_gnt, 1'b1);
    check("lk_c2_m0_gnt", m0_gnt, 1'b0);
    check("lk_c2_ram_we", ram_we, 4'hF);
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    settle();
    check("lk_c3_m0_gnt", m0_gnt, 1'b1);
    check("lk_c3_no_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    tick();
    clear_inputs();
    settle();
    check("lk_c4_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    tick();

    // ---------------- watchdog: m0 locks then idles (LOCK_MAX=4) ------------
    m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 32'h30;
    settle();
    check("wd_c0_m0_gnt", m0_gnt, 1'b1);
    tick();
    clear_inputs();
    m1_req = 1'b1; m1_addr = 32'h34;
    for (int k = 1; k <= 3; k++) begin
      settle();
      check($sformatf("wd_c%0d_m1_gnt", k), m1_gnt, 1'b0);
      check($sformatf("wd_c%0d_lock_err", k), lock_err, 1'b0);
      tick();
    end
    // expiry cycle: owner's locked access still executes, lock is dropped
    m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 32'h10;
    settle();
    check("wd_c4_lock_err", lock_err, 1'b1);
    check("wd_c4_m0_gnt",   m0_gnt,   1'b1);
    check("wd_c4_m1_gnt",   m1_gnt,   1'b0);
    tick();
    m0_lock = 1'b0;
    settle();
    // both request: the previous owner (m0) loses the tie
    check("wd_c5_lock_err",  lock_err,  1'b0);
    check("wd_c5_m1_gnt",    m1_gnt,    1'b1);
    check("wd_c5_m0_gnt",    m0_gnt,    1'b0);
    check("wd_c5_m0_rdata",  m0_rdata,  32'hDEAD_BEEF);
    tick();
    m1_req = 1'b0;
    settle();
    check("wd_c6_m0_gnt",    m0_gnt,    1'b1);
    check("wd_c6_m1_rdata",  m1_rdata,  32'h2222_2222);
    tick();
    clear_inputs();

    // ---------------- both lock in IDLE; release coincides with expiry -----
    m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 32'h30;
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h34;
    settle();
    check("bl_c0_m1_gnt", m1_gnt, 1'b1);
    check("bl_c0_m0_gnt", m0_gnt, 1'b0);
    tick();
    m1_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      settle();
      check($sformatf("bl_c%0d_m0_gnt", k), m0_gnt, 1'b0);
      tick();
    end
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = 32'h28; m1_wdata = 32'h0; m1_wstrb = 4'hF;
    settle();
    check("bl_c4_m1_gnt",   m1_gnt,   1'b1);
    check("bl_c4_lock_err", lock_err, 1'b0);
    check("bl_c4_m0_gnt",   m0_gnt,   1'b0);
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    m0_lock = 1'b0;
    settle();
    check("bl_c5_m0_gnt",   m0_gnt,   1'b1);
    check("bl_c5_lock_err", lock_err, 1'b0);
    tick();
    clear_inputs();

    // ---------------- reset during a pending m0 read -----------------------
    m0_req = 1'b1; m0_addr = 32'h10;
    settle();
    check("rp_c0_m0_gnt", m0_gnt, 1'b1);
    tick();
    rst_n  = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h34;
    settle();
    check("rp_rst_m0_rvalid", m0_rvalid, 1'b0);
    check("rp_rst_m0_rdata",  m0_rdata,  32'h0);
    check("rp_rst_gnts",      {m0_gnt, m1_gnt}, 2'b00);
    check("rp_rst_ram_en",    ram_en,    1'b0);
    check("rp_rst_ram_addr",  ram_addr,  32'h0);
    tick();
    rst_n = 1'b1;
    settle();
    check("rp_rel_m0_rvalid", m0_rvalid, 1'b0);
    check("rp_rel_m0_gnt",    m0_gnt,    1'b1);
    check("rp_rel_m1_gnt",    m1_gnt,    1'b0);
    tick();
    clear_inputs();
    settle();
    check("rp_post_m0_rvalid", m0_rvalid, 1'b1);
    check("rp_post_m0_rdata",  m0_rdata,  32'hDEAD_BEEF);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
